// File: rtl/ins_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and the CPU stage.
package ins_fetch_pkg;

    // Instruction word layout: 3 op + 5 rdest + 5 rs1 + 5 rs2
    localparam int OP_WIDTH  = 3;
    localparam int REG_AW    = 5;
    localparam int INS_WIDTH = OP_WIDTH + 3 * REG_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ins_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with head word on dout.
module ins_fifo #(
    parameter int width = 18,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         din,
    output logic [width-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(depth):0]   count
);
    localparam int PW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(depth));
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only legal when a pop frees a slot this cycle
    assign do_push = push && (!full || do_pop);
    // Empty buffer presents zero so the consumer never sees stale words
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; no reset needed, occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch: program memory, prefetch control FSM and output buffer.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int ins_width  = INS_WIDTH,
    parameter int mem_depth  = 16,
    parameter int fifo_depth = 4,
    parameter int aw         = $clog2(mem_depth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [aw-1:0]        wr_addr,
    input  logic [ins_width-1:0] wr_data,
    input  logic                 start,
    input  logic [aw:0]          prog_len,
    output logic [ins_width-1:0] ins,
    output logic                 ins_valid,
    input  logic                 ins_ready,
    output logic [aw-1:0]        pc,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(fifo_depth) + 1;

    fetch_state_t         state, state_nxt;
    logic [ins_width-1:0] imem [mem_depth];
    logic [ins_width-1:0] rdata;
    logic                 rd_vld;     // read issued last cycle, rdata valid now
    logic [aw:0]          plen, fetched, fetched_inc;
    logic                 issue;
    logic [CW-1:0]        f_count;
    logic                 f_empty, f_full;

    // Reads in flight count against capacity so the buffer can never overflow
    assign issue       = (state == FETCH) && ((int'(f_count) + int'(rd_vld)) < fifo_depth);
    assign fetched_inc = fetched + (aw+1)'(1);

    // Program memory load, allowed only while idle
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) imem[wr_addr] <= wr_data;
    end

    // Synchronous read port, one cycle latency
    always_ff @(posedge clk) begin
        if (issue) rdata <= imem[pc];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (prog_len == '0) ? DONE : FETCH;
            FETCH: if (issue && fetched_inc == plen) state_nxt = DRAIN;
            DRAIN: if (f_empty && !rd_vld) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Fetch address, progress counter and read-in-flight flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= '0;
            fetched <= '0;
            plen    <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= issue;
            if (state == IDLE && start) begin
                plen    <= prog_len;
                pc      <= '0;
                fetched <= '0;
            end else if (issue) begin
                fetched <= fetched_inc;
                // Hold at the top address so a full-memory program cannot wrap pc
                if (pc != aw'(mem_depth - 1)) pc <= pc + 1'b1;
            end
        end
    end

    ins_fifo #(
        .width (ins_width),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_vld),
        .pop   (ins_ready),
        .din   (rdata),
        .dout  (ins),
        .empty (f_empty),
        .full  (f_full),
        .count (f_count)
    );

    assign ins_valid = !f_empty;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: load, stream, stall, throttle, reset, write lockout.
module tb_ins_fetch;
    localparam int IW = 18;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [IW-1:0] wr_data;
    logic          start;
    logic [AW:0]   prog_len;
    logic [IW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] w [8];

    ins_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .prog_len  (prog_len),
        .ins       (ins),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .pc        (pc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [IW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Bounded wait for the done pulse, then confirm it lasts one cycle
    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (done) seen = 1;
            else step();
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Start a program with ins_ready held high; optionally attempt a write while busy
    task automatic run_seq(input string tag, input int len, input bit poke);
        ins_ready = 1'b1;
        prog_len  = (AW+1)'(len);
        start     = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_v0"}, 32'(ins_valid), 32'd0);
        if (poke) begin
            wr_en = 1'b1; wr_addr = 4'd1; wr_data = 18'h3FFFF;
        end
        step();
        wr_en = 1'b0;
        chk({tag, "_v1"}, 32'(ins_valid), 32'd0);
        step();
        for (int k = 0; k < len; k++) begin
            chk($sformatf("%s_valid%0d", tag, k), 32'(ins_valid), 32'd1);
            chk($sformatf("%s_word%0d", tag, k), 32'(ins), 32'(w[k]));
            step();
        end
        wait_done(tag);
    endtask

    initial begin
        int n;
        int npulse;
        w[0] = 18'h00441; w[1] = 18'h08C41; w[2] = 18'h0C865; w[3] = 18'h10123;
        w[4] = 18'h14456; w[5] = 18'h18789; w[6] = 18'h1CABC; w[7] = 18'h20DEF;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; prog_len = '0; ins_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_ins",   32'(ins), 32'd0);
        chk("rst_pc",    32'(pc), 32'd0);
        rst = 1'b0;
        step();
        for (int i = 0; i < 8; i++) wr(AW'(i), w[i]);

        // Basic three-word program at full rate
        run_seq("basic", 3, 1'b0);
        chk("basic_pc", 32'(pc), 32'd3);

        // Stalled consumer: buffer fills to depth, fetch stops at pc=4
        ins_ready = 1'b0;
        prog_len  = 5'd8;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        // start while busy must be ignored
        start = 1'b1; prog_len = 5'd2;
        step();
        start = 1'b0; prog_len = 5'd8;
        for (int i = 0; i < 4; i++) step();
        chk("stall_count", 32'(dut.u_fifo.count), 32'd4);
        chk("stall_pc",    32'(pc), 32'd4);
        chk("stall_valid", 32'(ins_valid), 32'd1);
        chk("stall_ins",   32'(ins), 32'(w[0]));
        ins_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("stall_v%0d", k), 32'(ins_valid), 32'd1);
            chk($sformatf("stall_w%0d", k), 32'(ins), 32'(w[k]));
            step();
        end
        chk("stall_empty", 32'(ins_valid), 32'd0);
        wait_done("stall");

        // Throttled consumer: ready alternates, count transfers
        prog_len = 5'd6;
        start    = 1'b1;
        ins_ready = 1'b0;
        step();
        start  = 1'b0;
        n      = 0;
        npulse = 0;
        for (int c = 0; c < 40; c++) begin
            ins_ready = c[0] ? 1'b0 : 1'b1;
            if (done) npulse++;
            if (ins_valid && ins_ready) begin
                if (n < 8) chk($sformatf("thr_w%0d", n), 32'(ins), 32'(w[n]));
                n++;
            end
            step();
        end
        chk("thr_transfers", 32'(n), 32'd6);
        chk("thr_done_pulses", 32'(npulse), 32'd1);
        chk("thr_idle", 32'(busy), 32'd0);

        // Empty program: done right after start; start during DONE ignored
        ins_ready = 1'b1;
        prog_len  = 5'd0;
        start     = 1'b1;
        step();
        chk("zero_done",  32'(done), 32'd1);
        chk("zero_valid", 32'(ins_valid), 32'd0);
        prog_len = 5'd3;
        step();
        start = 1'b0;
        chk("zero_pulse", 32'(done), 32'd0);
        chk("zero_ignore_start", 32'(busy), 32'd0);
        chk("zero_valid2", 32'(ins_valid), 32'd0);
        step();

        // Reset in the middle of fetching with two words buffered
        ins_ready = 1'b0;
        prog_len  = 5'd8;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("mid_count", 32'(dut.u_fifo.count), 32'd2);
        chk("mid_valid", 32'(ins_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ins_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_pc",    32'(pc), 32'd0);
        chk("mid_rst_ins",   32'(ins), 32'd0);
        #2;
        rst = 1'b0;
        step();
        run_seq("restart", 3, 1'b0);

        // Write during a run is ignored; a later run still sees original imem[1]
        run_seq("wrbusy", 3, 1'b1);
        run_seq("wrafter", 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ins_fetch.md
INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 SHALL have parameter ins_width, default 18, meaning instruction word width (3 op + 5 rdest + 5 rs1 + 5 rs2).
REQ-002 SHALL have parameter mem_depth, default 16, meaning instruction memory words.
REQ-003 SHALL have parameter fifo_depth, default 4, meaning prefetch buffer entries (power of two).
REQ-004 SHALL have parameter aw, default $clog2(mem_depth), meaning address width.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1  meaning instruction memory write strobe.
REQ-008 SHALL have port wr_addr  input  aw  meaning instruction memory write address.
REQ-009 SHALL have port wr_data  input  ins_width  meaning instruction memory write data.
REQ-010 SHALL have port start  input  1  meaning begin fetching at address 0.
REQ-011 SHALL have port prog_len  input  aw+1  meaning number of instructions to fetch, sampled when start is accepted.
REQ-012 SHALL have port ins  output  ins_width  meaning the instruction at the head of the prefetch buffer, driving the CPU ins input.
REQ-013 SHALL have port ins_valid  output  1  meaning ins holds a valid instruction.
REQ-014 SHALL have port ins_ready  input  1  meaning the consumer takes ins this cycle.
REQ-015 SHALL have port pc  output  aw  meaning the next fetch address.
REQ-016 SHALL have port busy  output  1  meaning the FSM is not in IDLE.
REQ-017 SHALL have port done  output  1  meaning a one-cycle pulse when the program is fully issued.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, DRAIN and DONE.
REQ-019 IDLE: start=1 -> latch prog_len, pc<=0, go to FETCH; if prog_len=0, go directly to DONE.
REQ-020 SHALL write memory on wr_en in IDLE only; wr_en in any other state SHALL be ignored.
REQ-021 FETCH: a read of imem[pc] SHALL be issued when (fifo count + reads in flight) < fifo_depth, evaluated before the same-cycle pop; each issued read increments pc and a fetched counter.
REQ-022 SHALL use a synchronous memory read with 1-cycle latency: the word is pushed into the FIFO the cycle after issue.
REQ-023 FETCH -> DRAIN SHALL occur in the cycle the fetched counter reaches the latched prog_len.
REQ-024 DRAIN -> DONE SHALL occur when the FIFO is empty and no read is in flight.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; start is ignored in DONE.
REQ-026 ins_valid SHALL equal FIFO non-empty.
REQ-027 ins SHALL be the FIFO head word, stable while ins_valid=1 and ins_ready=0.
REQ-028 A transfer SHALL occur on a cycle with ins_valid and ins_ready both 1; in-order delivery is required, with no loss or duplication.
REQ-029 A simultaneous push and pop SHALL leave count unchanged; a pop when empty SHALL have no effect; pointers wrap modulo fifo_depth.
REQ-030 start while busy SHALL be ignored.
REQ-031 SHALL achieve a maximum throughput of 1 instruction per cycle with ins_ready held at 1; first ins_valid SHALL appear 2 cycles after start is accepted.
REQ-032 pc SHALL saturate at its value after the last fetch; it never wraps within a program.

Reset
REQ-033 rst SHALL force asynchronously: state=IDLE, pc=0, FIFO empty, in-flight cleared, ins_valid=0, busy=0, done=0, ins=0.
REQ-034 rst mid-program SHALL discard buffered instructions; memory contents SHALL be preserved.

Structure
REQ-035 The FSM state encodings and the default widths (ins_width=18, op_width=3, reg address width=5) SHALL reside in a shared package used by the CPU stage.
REQ-036 The prefetch buffer SHALL be a sub-module named ins_fifo (parameters width, depth; ports push, pop, din, dout, empty, full, count).

Verification
REQ-037 Load 3 words 0x00441, 0x08C41, 0x0C865; start, prog_len=3, ins_ready=1 -> ins_valid first at cycle 2; words issued in order on 3 consecutive cycles; done pulse follows, then busy=0.
REQ-038 prog_len=8, ins_ready=0 for 10 cycles -> count stops at 4; pc=4; ins held at imem[0]; then ins_ready=1 -> all 8 words delivered in order, with no gaps after the first.
REQ-039 ins_ready toggling 1,0,1,0 with prog_len=6 -> exactly 6 transfers, with no duplicates or drops.
REQ-040 prog_len=0 -> done pulse one cycle after start; ins_valid remains 0.
REQ-041 rst asserted mid-FETCH with 2 words buffered -> ins_valid=0 immediately; busy=0; restart with start reproduces the sequence from imem[0].
REQ-042 wr_en while busy writing address 1 with 0x3FFFF -> ignored; a later run still issues the original imem[1].
